// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM status and memory-controller state types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        SNOOP  = 3'd2,
        C2C    = 3'd3,
        RAMRD  = 3'd4,
        IFETCH = 3'd5
    } memctl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; pointer moves past the core just served
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic       grant
);

    logic ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~served;
        end
    end

    always_comb begin
        grant = (req == 2'b11) ? ptr : req[1];
    end

endmodule

// File: rtl/coherent_mem_arbiter.sv
// rtl/coherent_mem_arbiter.sv - dual-core RAM arbiter with MSI snoop; MEMCTL_PERF_EN adds ack counters
module coherent_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  word_t [CPUS-1:0]     iaddr,
    output logic [CPUS-1:0]      iwait,
    output word_t [CPUS-1:0]     iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    output logic [CPUS-1:0]      dwait,
    output word_t [CPUS-1:0]     dload,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      cctrans,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output word_t [CPUS-1:0]     ccsnoopaddr,
`ifdef MEMCTL_PERF_EN
    output logic [31:0]          c2c_count,
    output logic [31:0]          ramrd_count,
    output logic [31:0]          wb_count,
    output logic [31:0]          ifetch_count,
`endif
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore
);

    memctl_state_t state, next_state;
    logic g, g_next, o;
    logic d_gnt, i_gnt;
    logic [1:0] d_req;
    logic ack_wb, ack_rd, ack_c2c, ack_if;

    assign o     = ~g;
    assign d_req = (|dWEN) ? dWEN : dREN;

    rr_arb2 u_data_arb (
        .clk     (CLK),
        .rst_n   (nRST),
        .req     (d_req),
        .advance (ack_wb | ack_rd | ack_c2c),
        .served  (g),
        .grant   (d_gnt)
    );

    rr_arb2 u_inst_arb (
        .clk     (CLK),
        .rst_n   (nRST),
        .req     (iREN),
        .advance (ack_if),
        .served  (g),
        .grant   (i_gnt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            g     <= 1'b0;
        end else begin
            state <= next_state;
            g     <= g_next;
        end
    end

    // Every active state first checks that the granted request is still held; a drop aborts silently.
    always_comb begin
        next_state  = state;
        g_next      = g;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccsnoopaddr = '0;
        ccwait      = '0;
        ccinv       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        ack_wb      = 1'b0;
        ack_rd      = 1'b0;
        ack_c2c     = 1'b0;
        ack_if      = 1'b0;
        case (state)
            IDLE: begin
                if (|dWEN) begin
                    next_state = WB;
                    g_next     = d_gnt;
                end else if (|dREN) begin
                    next_state = SNOOP;
                    g_next     = d_gnt;
                end else if (|iREN) begin
                    next_state = IFETCH;
                    g_next     = i_gnt;
                end
            end
            WB: begin
                if (!dWEN[g]) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[g];
                    ramstore = dstore[g];
                    if (ramstate == ACCESS) begin
                        dwait[g]   = 1'b0;
                        ack_wb     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            SNOOP: begin
                if (!dREN[g]) begin
                    next_state = IDLE;
                end else begin
                    ccwait[o]      = 1'b1;
                    ccsnoopaddr[o] = daddr[g];
                    ccinv[o]       = ccwrite[g];
                    next_state     = (cctrans[o] && ccwrite[o]) ? C2C : RAMRD;
                end
            end
            C2C: begin
                if (!dREN[g]) begin
                    next_state = IDLE;
                end else begin
                    ccwait[o] = 1'b1;
                    // The peer supplies the line through its own flush write.
                    if (dWEN[o]) begin
                        ramWEN   = 1'b1;
                        ramaddr  = daddr[o];
                        ramstore = dstore[o];
                        dload[g] = dstore[o];
                        if (ramstate == ACCESS) begin
                            dwait[g]   = 1'b0;
                            dwait[o]   = 1'b0;
                            ack_c2c    = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end
            end
            RAMRD: begin
                if (!dREN[g]) begin
                    next_state = IDLE;
                end else begin
                    ccwait[o] = 1'b1;
                    ramREN    = 1'b1;
                    ramaddr   = daddr[g];
                    dload[g]  = ramload;
                    if (ramstate == ACCESS) begin
                        dwait[g]   = 1'b0;
                        ack_rd     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            IFETCH: begin
                if (!iREN[g]) begin
                    next_state = IDLE;
                end else begin
                    ramREN   = 1'b1;
                    ramaddr  = iaddr[g];
                    iload[g] = ramload;
                    if (ramstate == ACCESS) begin
                        iwait[g]   = 1'b0;
                        ack_if     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef MEMCTL_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            c2c_count    <= '0;
            ramrd_count  <= '0;
            wb_count     <= '0;
            ifetch_count <= '0;
        end else begin
            c2c_count    <= c2c_count + 32'(ack_c2c);
            ramrd_count  <= ramrd_count + 32'(ack_rd);
            wb_count     <= wb_count + 32'(ack_wb);
            ifetch_count <= ifetch_count + 32'(ack_if);
        end
    end
`endif

endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// tb/tb_coherent_mem_arbiter.sv - directed and random checks against a transaction-level model
module tb_coherent_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    logic [1:0] iREN, dREN, dWEN, ccwrite, cctrans;
    word_t [1:0] iaddr, daddr, dstore;
    word_t ramload;
    ramstate_t ramstate;
    logic [1:0] iwait, dwait, ccwait, ccinv;
    word_t [1:0] iload, dload, ccsnoopaddr;
    logic ramREN, ramWEN;
    word_t ramaddr, ramstore;
`ifdef MEMCTL_PERF_EN
    logic [31:0] c2c_count, ramrd_count, wb_count, ifetch_count;
`endif

    coherent_mem_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
`ifdef MEMCTL_PERF_EN
        .c2c_count(c2c_count), .ramrd_count(ramrd_count),
        .wb_count(wb_count), .ifetch_count(ifetch_count),
`endif
        .ramload(ramload), .ramstate(ramstate),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: at most one outstanding transaction, described by kind, owner and read progress.
    typedef enum {K_WB, K_RD, K_FETCH} kind_e;
    bit    m_busy, m_core, m_dptr, m_iptr;
    kind_e m_kind;
    int    m_phase;  // reads: 0 = snooping, 1 = filling from RAM, 2 = cache-to-cache
    int    n_wb, n_rd, n_c2c, n_if;

    logic [1:0] e_iwait, e_dwait, e_ccwait, e_ccinv;
    word_t [1:0] e_iload, e_dload, e_snoop;
    logic e_ren, e_wen, e_ack;
    word_t e_ramaddr, e_ramstore;

    function automatic bit pick(input logic [1:0] r, input bit ptr);
        return (r == 2'b11) ? ptr : r[1];
    endfunction

    function automatic bit held();
        case (m_kind)
            K_WB:    return dWEN[m_core];
            K_RD:    return dREN[m_core];
            default: return iREN[m_core];
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_core = 0; m_dptr = 0; m_iptr = 0; m_phase = 0;
    endtask

    task automatic model_outputs();
        bit c, o;
        c = m_core;
        o = ~m_core;
        e_iwait = '1; e_dwait = '1; e_iload = '0; e_dload = '0; e_snoop = '0;
        e_ccwait = '0; e_ccinv = '0; e_ren = 0; e_wen = 0;
        e_ramaddr = '0; e_ramstore = '0; e_ack = 0;
        if (m_busy && held()) begin
            e_ack = (ramstate == ACCESS);
            case (m_kind)
                K_WB: begin
                    e_wen = 1; e_ramaddr = daddr[c]; e_ramstore = dstore[c];
                    if (e_ack) e_dwait[c] = 0;
                end
                K_FETCH: begin
                    e_ren = 1; e_ramaddr = iaddr[c]; e_iload[c] = ramload;
                    if (e_ack) e_iwait[c] = 0;
                end
                default: begin
                    e_ccwait[o] = 1;
                    if (m_phase == 0) begin
                        e_snoop[o] = daddr[c]; e_ccinv[o] = ccwrite[c]; e_ack = 0;
                    end else if (m_phase == 1) begin
                        e_ren = 1; e_ramaddr = daddr[c]; e_dload[c] = ramload;
                        if (e_ack) e_dwait[c] = 0;
                    end else if (dWEN[o]) begin
                        e_wen = 1; e_ramaddr = daddr[o]; e_ramstore = dstore[o];
                        e_dload[c] = dstore[o];
                        if (e_ack) begin e_dwait[c] = 0; e_dwait[o] = 0; end
                    end else begin
                        e_ack = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic model_tick();
        bit o;
        o = ~m_core;
        if (!nRST) begin
            model_reset();
        end else if (m_busy) begin
            if (!held()) begin
                m_busy = 0;
            end else if (e_ack) begin
                m_busy = 0;
                if (m_kind == K_FETCH) begin m_iptr = o; n_if++; end
                else begin
                    m_dptr = o;
                    if (m_kind == K_WB) n_wb++;
                    else if (m_phase == 2) n_c2c++;
                    else n_rd++;
                end
            end else if (m_kind == K_RD && m_phase == 0) begin
                m_phase = (cctrans[o] && ccwrite[o]) ? 2 : 1;
            end
        end else if (|dWEN) begin
            m_busy = 1; m_kind = K_WB; m_core = pick(dWEN, m_dptr);
        end else if (|dREN) begin
            m_busy = 1; m_kind = K_RD; m_phase = 0; m_core = pick(dREN, m_dptr);
        end else if (|iREN) begin
            m_busy = 1; m_kind = K_FETCH; m_core = pick(iREN, m_iptr);
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        if (!nRST) model_reset();
        #1;
        model_outputs();
        check("ram_en", {ramREN, ramWEN}, {e_ren, e_wen});
        check("ramaddr", ramaddr, e_ramaddr);
        check("ramstore", ramstore, e_ramstore);
        check("iwait", iwait, e_iwait);
        check("dwait", dwait, e_dwait);
        check("ccwait", ccwait, e_ccwait);
        check("ccinv", ccinv, e_ccinv);
        check("ccsnoopaddr", ccsnoopaddr, e_snoop);
        check("iload", iload, e_iload);
        check("dload", dload, e_dload);
        @(posedge CLK);
        model_tick();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    task automatic run(input int n, input ramstate_t rs);
        for (int k = 0; k < n; k++) begin
            ramstate = rs;
            ramload = $urandom;
            cycle();
        end
    endtask

    int dpend [2];
    int ipend [2];

    initial begin
        clear_inputs();
        n_wb = 0; n_rd = 0; n_c2c = 0; n_if = 0;
        nRST = 1'b0;
        @(negedge CLK);
        cycle();
        nRST = 1'b1;
        cycle();

        // Fetch with two BUSY cycles before ACCESS
        iREN[0] = 1; iaddr[0] = 32'h100;
        run(1, FREE); run(2, BUSY); run(1, ACCESS);
        iREN = '0; run(1, FREE);

        // Both cores fetching: alternating grants
        iREN = 2'b11; iaddr[0] = 32'h400; iaddr[1] = 32'h800;
        run(8, ACCESS);
        iREN = '0; run(1, FREE);

        // Data read beats fetch
        dREN[1] = 1; daddr[1] = 32'h500; iREN[0] = 1; iaddr[0] = 32'h104;
        run(2, BUSY); run(1, ACCESS); dREN = '0; run(2, ACCESS);
        clear_inputs(); run(1, FREE);

        // Clean read-exclusive miss
        dREN[0] = 1; daddr[0] = 32'h200; ccwrite[0] = 1;
        run(2, BUSY); run(1, ACCESS);
        clear_inputs(); run(1, FREE);

        // Cache-to-cache transfer from dirty peer
        dREN[0] = 1; daddr[0] = 32'h300; cctrans[1] = 1; ccwrite[1] = 1;
        run(2, BUSY);
        dWEN[1] = 1; daddr[1] = 32'h300; dstore[1] = 32'hDEADBEEF;
        run(1, BUSY); run(1, ACCESS);
        clear_inputs(); run(1, FREE);

        // Writeback ahead of a read miss
        dWEN[1] = 1; daddr[1] = 32'h600; dstore[1] = 32'h1234_5678;
        dREN[0] = 1; daddr[0] = 32'h700;
        run(1, BUSY); run(1, ACCESS);
        dWEN = '0; run(3, ACCESS);
        clear_inputs(); run(1, FREE);

        // Reset during a RAM read
        dREN[0] = 1; daddr[0] = 32'h900;
        run(3, BUSY);
        nRST = 1'b0; run(2, ACCESS);
        nRST = 1'b1; clear_inputs(); run(1, FREE);

        // Random traffic: requests held until acked, occasionally dropped
        foreach (dpend[c]) begin dpend[c] = 0; ipend[c] = 0; end
        e_dwait = '1; e_iwait = '1; e_ccwait = '0;
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (dpend[c] != 0 && (!e_dwait[c] || $urandom_range(0, 31) == 0)) begin
                    dpend[c] = 0;
                end else if (dpend[c] == 0 &&
                             ($urandom_range(0, 3) == 0 || (e_ccwait[c] && $urandom_range(0, 1) == 0))) begin
                    dpend[c] = e_ccwait[c] ? 2 : int'($urandom_range(1, 2));
                    daddr[c] = {$urandom_range(0, 255), 2'b00};
                    dstore[c] = $urandom;
                end
                if (ipend[c] != 0 && (!e_iwait[c] || $urandom_range(0, 31) == 0)) begin
                    ipend[c] = 0;
                end else if (ipend[c] == 0 && $urandom_range(0, 3) == 0) begin
                    ipend[c] = 1;
                    iaddr[c] = {$urandom_range(0, 255), 2'b00};
                end
                dREN[c] = (dpend[c] == 1);
                dWEN[c] = (dpend[c] == 2);
                iREN[c] = (ipend[c] == 1);
            end
            ccwrite = 2'($urandom);
            cctrans = 2'($urandom);
            ramload = $urandom;
            ramstate = ($urandom_range(0, 1) == 0) ? ACCESS : ramstate_t'($urandom_range(0, 3));
            cycle();
        end

`ifdef MEMCTL_PERF_EN
        check("wb_count", wb_count, n_wb);
        check("ramrd_count", ramrd_count, n_rd);
        check("c2c_count", c2c_count, n_c2c);
        check("ifetch_count", ifetch_count, n_if);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coherent_mem_arbiter.md
Name: coherent_mem_arbiter

Overview:
- Dual-core memory controller behind the cache coherence bus.
- Shares one single-port RAM between two I-caches and two D-caches.
- Arbitrates fetch, read-miss and writeback requests, and sequences a one-cycle MSI snoop of the peer D-cache on every data read.
- On a dirty peer hit it performs a cache-to-cache transfer with simultaneous RAM writeback.

Parameters:
CPUS, 2, number of cores; only 2 supported, index 0/1, peer of core g is o = ~g.

Ports:
CLK  in  1  system clock, all state on rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  CPUS  instruction read request per core
iaddr  in  CPUS x 32  instruction address (word_t)
iwait  out  CPUS  1 = instruction request not yet serviced
iload  out  CPUS x 32  instruction data, valid when iwait[i]=0
dREN  in  CPUS  data read (miss fill) request
dWEN  in  CPUS  data write (writeback / snoop flush) request
daddr  in  CPUS x 32  data address
dstore  in  CPUS x 32  data write value
dwait  out  CPUS  1 = data request not yet serviced
dload  out  CPUS x 32  data read value, valid when dwait[i]=0
ccwrite  in  CPUS  with dREN: read-exclusive (BusRdX); in snoop response: peer line is M
cctrans  in  CPUS  cache transitioning; in snoop response: peer holds the line
ccwait  out  CPUS  snoop in progress, block the core
ccinv  out  CPUS  invalidate the line at ccsnoopaddr
ccsnoopaddr  out  CPUS x 32  snooped address
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data

Behaviour:
- Reset (async, nRST=0): state IDLE; both RR pointers to 0. Combinational defaults hold in IDLE and any state not driving a signal: iwait/dwait = all 1s; iload/dload, ramaddr, ramstore, ccsnoopaddr = 0; ramREN, ramWEN, ccwait, ccinv = 0.
- States: IDLE, WB, SNOOP, C2C, RAMRD, IFETCH; registered, encoded as memctl_state_t.
- IDLE priority: any dWEN, then any dREN, then any iREN. Ties between cores use the data RR pointer (data requests) or the instruction RR pointer (fetches). The grant g is latched.
- IDLE transitions: dWEN -> WB, dREN -> SNOOP, iREN -> IFETCH.
- A pointer flips to the non-granted core only when its transaction acks. A dropped request leaves the pointer unchanged.
- WB:
  - Drives ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - When ramstate==ACCESS: dwait[g]=0 combinationally that cycle, then -> IDLE.
- SNOOP, exactly 1 cycle:
  - ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g].
  - Samples the peer: cctrans[o]&ccwrite[o] -> C2C, else -> RAMRD.
  - No RAM access in this state.
- C2C:
  - ccwait[o] held.
  - ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[g]=dstore[o]. Enters only once dWEN[o]=1; until then RAM enables stay 0.
  - On ACCESS: dwait[g]=0 and dwait[o]=0 in the same cycle, then -> IDLE.
- RAMRD:
  - ccwait[o] held.
  - ramREN=1, ramaddr=daddr[g], dload[g]=ramload.
  - On ACCESS: dwait[g]=0, then -> IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[g], iload[g]=ramload. On ACCESS: iwait[g]=0, then -> IDLE.
- Latency: minimum 1 cycle from the grant cycle to ack for WB and IFETCH, and 2 cycles for data reads.
- Error and stall: ramstate BUSY, FREE or ERROR = no ack, and the state holds.
- Request drop: if the granted request deasserts before ack, go -> IDLE with no ack and release ccwait.
- Address changes while a request is pending are not supported. Multi-word blocks are sequenced by the cache as separate requests.
- Simultaneous events: a peer request arriving during a transaction waits; its wait stays 1. A reset mid-transaction aborts it with no ack.

Optional Feature:
- MEMCTL_PERF_EN defined:
  - Adds outputs c2c_count, ramrd_count, wb_count, ifetch_count (32 bits each).
  - Each increments on an ack of its type, wraps at 2^32, and resets to 0.
- Undefined: the ports and counters are absent; all behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg: word_t and ramstate_t, both existing; add memctl_state_t.
- Sub-module rr_arb2: a 2-way round-robin arbiter with req[1:0], advance and grant index. It is instantiated twice, once for data and once for instruction requests.

Test Plan:
- Fetch: iREN[0]=1, iaddr[0]=0x100, ram ACCESS after 2 BUSY cycles -> ramaddr=0x100, iload[0]=ramload, iwait[0] low for exactly 1 cycle.
- Contention: iREN=2'b11 held -> grants alternate 0,1,0,1. With dREN[1] and iREN[0] together, the data request wins.
- Clean read miss: dREN[0]=1, daddr=0x200, ccwrite[0]=1, peer cctrans=0 -> SNOOP with ccinv[1]=1 and ccsnoopaddr[1]=0x200, then RAMRD, dwait[0] drops on ACCESS.
- C2C: dREN[0]=1 at 0x300, peer cctrans=ccwrite=1, dWEN[1]=1, dstore[1]=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, dload[0]=0xDEADBEEF, dwait[0] and dwait[1] drop together.
- Writeback priority: dWEN[1] and dREN[0] together -> WB for core 1 first, then SNOOP for core 0.
- Reset mid-op: nRST low during RAMRD -> all outputs to reset values immediately, no ack, state IDLE.
